// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: stopwatch start/stop/lap/clear FSM with synchronized buttons
// and a DIV-cycle prescaler that produces the time-counter tick.
module stopwatch_ctrl #(
   parameter int unsigned DIV = 100000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start_stop,
   input  logic       lap,
   input  logic       clear,
   input  logic       max_hit,
   output logic       en,
   output logic       tick,
   output logic       clr,
   output logic       freeze,
   output logic [2:0] state
);
   localparam int unsigned W = $clog2(DIV);
   localparam logic [W-1:0] TOP = W'(DIV - 1);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      RUN       = 3'd1,
      PAUSE     = 3'd2,
      LAP       = 3'd3,
      LAP_PAUSE = 3'd4
   } state_e;

   state_e       state_q, state_d;
   logic [2:0]   s1_q, s2_q, s3_q;
   logic [W-1:0] presc_q, presc_d;
   logic         clr_q, clr_d;
   logic         ss_p, lap_p, clr_p;

   // s1/s2 synchronize, s3 remembers the previous synchronized level
   assign {clr_p, lap_p, ss_p} = s2_q & ~s3_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1_q    <= '0;
         s2_q    <= '0;
         s3_q    <= '0;
         state_q <= IDLE;
         presc_q <= '0;
         clr_q   <= 1'b0;
      end else begin
         s1_q    <= {clear, lap, start_stop};
         s2_q    <= s1_q;
         s3_q    <= s2_q;
         state_q <= state_d;
         presc_q <= presc_d;
         clr_q   <= clr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      clr_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (ss_p) state_d = RUN;
            else if (clr_p) clr_d = 1'b1;
         end
         RUN: begin
            if (max_hit || ss_p) state_d = PAUSE;
            else if (lap_p) state_d = LAP;
         end
         PAUSE: begin
            if (clr_p) begin
               state_d = IDLE;
               clr_d   = 1'b1;
            end else if (ss_p && !max_hit) state_d = RUN;
         end
         LAP: begin
            if (max_hit || ss_p) state_d = LAP_PAUSE;
            else if (lap_p) state_d = RUN;
         end
         LAP_PAUSE: begin
            if (clr_p) begin
               state_d = IDLE;
               clr_d   = 1'b1;
            end else if (ss_p) state_d = max_hit ? LAP_PAUSE : LAP;
            else if (lap_p) state_d = PAUSE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign en     = state_q == RUN || state_q == LAP;
   assign freeze = state_q == LAP || state_q == LAP_PAUSE;
   assign tick   = en && presc_q == TOP;
   assign clr    = clr_q;
   assign state  = state_q;

   // holding while paused keeps the sub-tick fraction
   assign presc_d = clr_d ? '0 : !en ? presc_q : tick ? '0 : presc_q + 1'b1;
endmodule
